// File: rtl/demux_striping_param.sv
// N-lane round-robin byte-striping demux for the clk_2f transmit path.
// Lane count is reconfigurable at stripe boundaries; flush realigns to lane 0.
module demux_striping_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] lane_q,
  output logic              vld_q
);
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      lane_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= wr_en;
      if (wr_en) lane_q <= wr_data;
    end
  end
endmodule

module demux_striping_param #(
  parameter int DATA_W    = 32,
  parameter int NUM_LANES = 4,
  parameter int PTR_W     = 2
) (
  input  logic                        clk_2f,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [DATA_W-1:0]           data_input,
  input  logic [PTR_W-1:0]            lane_cfg,
  input  logic                        flush,
  output logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic [NUM_LANES-1:0]        valid_out,
  output logic                        stripe_done,
  output logic [7:0]                  partial_cnt,
  output logic [PTR_W-1:0]            cfg_active
);
  logic [PTR_W-1:0] ptr, ptr_nxt, cfg_nxt, wr_sel;
  logic             wr_any, done_nxt;
  logic [7:0]       pcnt_nxt;
  logic [NUM_LANES-1:0]             wr_onehot;
  logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;

  always_comb begin
    ptr_nxt  = ptr;
    cfg_nxt  = cfg_active;
    pcnt_nxt = partial_cnt;
    wr_sel   = ptr;
    wr_any   = 1'b0;
    done_nxt = 1'b0;
    if (flush) begin
      // abort the old stripe first, then a same-cycle word starts a fresh one
      cfg_nxt = lane_cfg;
      ptr_nxt = '0;
      if (ptr != '0 && partial_cnt != 8'hFF) pcnt_nxt = partial_cnt + 8'd1;
      if (valid_in) begin
        wr_sel = '0;
        wr_any = 1'b1;
        if (lane_cfg == '0) done_nxt = 1'b1;
        else                ptr_nxt  = PTR_W'(1);
      end
    end else if (valid_in) begin
      wr_any = 1'b1;
      if (ptr == cfg_active) begin
        ptr_nxt  = '0;
        done_nxt = 1'b1;
        cfg_nxt  = lane_cfg;
      end else begin
        ptr_nxt = ptr + PTR_W'(1);
      end
    end else if (ptr == '0) begin
      cfg_nxt = lane_cfg;
    end
    wr_onehot = wr_any ? (NUM_LANES'(1) << wr_sel) : '0;
  end

  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      ptr         <= '0;
      cfg_active  <= lane_cfg;
      partial_cnt <= '0;
      stripe_done <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      cfg_active  <= cfg_nxt;
      partial_cnt <= pcnt_nxt;
      stripe_done <= done_nxt;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_striping_lane #(.DATA_W(DATA_W)) u_lane (
      .clk_2f  (clk_2f),
      .reset   (reset),
      .wr_en   (wr_onehot[k]),
      .wr_data (data_input),
      .lane_q  (lane_q[k]),
      .vld_q   (valid_out[k])
    );
  end

  assign lane_data = lane_q;
endmodule

// File: tb/tb_demux_striping_param.sv
// Directed + randomized bench for demux_striping_param against a stripe-level model.
module tb_demux_striping_param;
  localparam int DATA_W = 32, NUM_LANES = 4, PTR_W = 2;
  localparam int LW = NUM_LANES*DATA_W;

  logic clk_2f = 0, reset = 0, valid_in = 0, flush = 0;
  logic [DATA_W-1:0] data_input = '0;
  logic [PTR_W-1:0]  lane_cfg = '0;
  logic [LW-1:0]        lane_data;
  logic [NUM_LANES-1:0] valid_out;
  logic                 stripe_done;
  logic [7:0]           partial_cnt;
  logic [PTR_W-1:0]     cfg_active;

  demux_striping_param #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .PTR_W(PTR_W)) dut (
    .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_input(data_input),
    .lane_cfg(lane_cfg), .flush(flush), .lane_data(lane_data), .valid_out(valid_out),
    .stripe_done(stripe_done), .partial_cnt(partial_cnt), .cfg_active(cfg_active));

  always #5 clk_2f = ~clk_2f;

  int passed = 0, total = 0;

  // reference model: stripe position, active lane count, abort counter, lane contents
  int m_pos, m_cfg, m_pcnt, m_vld_lane, m_done;
  logic [DATA_W-1:0] m_lane [NUM_LANES];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] m_lanes_flat();
    logic [LW-1:0] f;
    for (int k = 0; k < NUM_LANES; k++) f[k*DATA_W +: DATA_W] = m_lane[k];
    return f;
  endfunction

  task automatic model_edge(input logic rst_n, input logic v, input logic [DATA_W-1:0] d,
                            input int cfg, input logic fl);
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++) m_lane[k] = '0;
      m_pos = 0; m_cfg = cfg; m_pcnt = 0; m_vld_lane = -1; m_done = 0;
    end else if (fl) begin
      if (m_pos != 0) m_pcnt = (m_pcnt == 255) ? 255 : m_pcnt + 1;
      m_cfg = cfg;
      if (v) begin
        m_lane[0] = d; m_vld_lane = 0;
        m_done = (m_cfg == 0);
        m_pos  = (m_cfg == 0) ? 0 : 1;
      end else begin
        m_pos = 0; m_vld_lane = -1; m_done = 0;
      end
    end else if (v) begin
      m_lane[m_pos] = d; m_vld_lane = m_pos;
      m_done = (m_pos == m_cfg);
      if (m_done) m_cfg = cfg;
      m_pos = (m_pos + 1) % (m_cfg_old_plus1(m_done, m_pos));
    end else begin
      m_vld_lane = -1; m_done = 0;
      if (m_pos == 0) m_cfg = cfg;
    end
  endtask

  // next position after an accept: wrap after the last active lane of the old stripe
  function automatic int m_cfg_old_plus1(input int done, input int pos);
    return done ? pos + 1 : NUM_LANES;
  endfunction

  task automatic step(input logic rst_n, input logic v, input logic [DATA_W-1:0] d,
                      input int cfg, input logic fl);
    logic [NUM_LANES-1:0] ev;
    reset = rst_n; valid_in = v; data_input = d; lane_cfg = PTR_W'(cfg); flush = fl;
    @(posedge clk_2f);
    model_edge(rst_n, v, d, cfg, fl);
    #1;
    ev = (m_vld_lane < 0) ? '0 : NUM_LANES'(1) << m_vld_lane;
    chk("lane_data",   LW'(lane_data),   m_lanes_flat());
    chk("valid_out",   LW'(valid_out),   LW'(ev));
    chk("stripe_done", LW'(stripe_done), LW'(m_done));
    chk("partial_cnt", LW'(partial_cnt), LW'(m_pcnt));
    chk("cfg_active",  LW'(cfg_active),  LW'(m_cfg));
    #3;
  endtask

  initial begin
    logic [LW-1:0] exp_l;
    int cfg;
    #2;
    // 1: reset then full 4-lane stripe
    step(0, 0, 0, 3, 0); step(0, 1, 32'hFFFF_FFFF, 3, 0);
    chk("rst_lanes", LW'(lane_data), '0);
    step(1, 1, 32'hAAAAAAAA, 3, 0);
    chk("t1_vo0", LW'(valid_out), LW'(4'b0001));
    step(1, 1, 32'hBBBBBBBB, 3, 0);
    step(1, 1, 32'hCCCCCCCC, 3, 0);
    chk("t1_done_early", LW'(stripe_done), '0);
    step(1, 1, 32'hDDDDDDDD, 3, 0);
    chk("t1_vo3", LW'(valid_out), LW'(4'b1000));
    chk("t1_done", LW'(stripe_done), LW'(1'b1));
    exp_l = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    chk("t1_lanes", LW'(lane_data), exp_l);
    // 2: two-lane mode
    step(1, 0, 0, 1, 0);
    step(1, 1, 32'h11111111, 1, 0);
    step(1, 1, 32'h22222222, 1, 0);
    chk("t2_done", LW'(stripe_done), LW'(1'b1));
    step(1, 1, 32'h33333333, 1, 0);
    exp_l = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'h22222222, 32'h33333333};
    chk("t2_lanes", LW'(lane_data), exp_l);
    // 3: mid-stripe reconfig deferred to the wrap
    step(1, 1, 32'h44444444, 1, 0);
    step(1, 0, 0, 3, 0);
    step(1, 1, 32'h01010101, 3, 0); step(1, 1, 32'h02020202, 3, 0);
    step(1, 1, 32'h03030303, 1, 0);
    chk("t3_cfg_hold", LW'(cfg_active), LW'(2'd3));
    step(1, 1, 32'h04040404, 1, 0);
    chk("t3_vo3", LW'(valid_out), LW'(4'b1000));
    chk("t3_cfg_new", LW'(cfg_active), LW'(2'd1));
    step(1, 1, 32'h05050505, 1, 0);
    chk("t3_vo0", LW'(valid_out), LW'(4'b0001));
    // 4: flush with a same-cycle word
    step(0, 0, 0, 3, 0);
    step(1, 1, 32'h0A0A0A0A, 3, 0); step(1, 1, 32'h0B0B0B0B, 3, 0);
    step(1, 1, 32'h55555555, 3, 1);
    chk("t4_pcnt", LW'(partial_cnt), LW'(8'd1));
    chk("t4_vo", LW'(valid_out), LW'(4'b0001));
    chk("t4_lane0", LW'(lane_data[DATA_W-1:0]), LW'(32'h55555555));
    step(1, 1, 32'h66666666, 3, 0);
    chk("t4_ptr1", LW'(valid_out), LW'(4'b0010));
    // 5: gap
    step(1, 0, 0, 3, 1);
    step(1, 1, 32'h77777777, 3, 0);
    step(1, 0, 0, 3, 0);
    chk("t5_gap", LW'(valid_out), '0);
    step(1, 1, 32'h88888888, 3, 0);
    chk("t5_lane1", LW'(valid_out), LW'(4'b0010));
    // 6: saturation, then reset mid-stripe
    for (int i = 0; i < 300; i++) step(1, 1, $urandom, 3, 1);
    chk("t6_sat", LW'(partial_cnt), LW'(8'd255));
    step(1, 1, 32'h99999999, 3, 0);
    step(0, 0, 0, 2, 0);
    chk("t6_rst_lanes", LW'(lane_data), '0);
    chk("t6_rst_vo", LW'(valid_out), '0);
    chk("t6_rst_pcnt", LW'(partial_cnt), '0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cfg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : cfg;
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, $urandom, cfg,
           $urandom_range(0, 11) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/demux_striping_param.md
Name: demux_striping_param

Overview:
Parametrised N-lane byte-striping demultiplexer, the successor of the fixed 2-lane demux_striping on the PCIe physical-layer transmit path. It sits after the serialising front end in the clk_2f domain. Each valid input word is written round-robin to one of NUM_LANES lane registers. Runtime lane-count mode, stripe-boundary reconfiguration, flush/realign and a saturating partial-stripe counter are features the 2-lane version lacks.

Parameters:
DATA_W, 32, width of each data word and of each lane.
NUM_LANES, 4, physical lane count; power of two, 2..16.
PTR_W, 2, log2(NUM_LANES); lane pointer width.

Ports:
clk_2f  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = in reset).
valid_in  input  1  data_input holds a word this cycle.
data_input  input  DATA_W  word to stripe.
lane_cfg  input  PTR_W  requested active lanes minus 1 (0 = 1 lane … NUM_LANES-1 = all lanes).
flush  input  1  abort current stripe; realign pointer to lane 0.
lane_data  output  NUM_LANES*DATA_W  flattened lane registers; lane k at bits [k*DATA_W +: DATA_W].
valid_out  output  NUM_LANES  per-lane valid, one-hot or zero.
stripe_done  output  1  pulse: last active lane written this cycle.
partial_cnt  output  8  saturating count of stripes aborted by flush.
cfg_active  output  PTR_W  lane configuration currently in force.

Behaviour:
- Reset (reset==0 at posedge): lane_data=0, valid_out=0, stripe_done=0, partial_cnt=0, ptr=0, cfg_active<=lane_cfg. valid_in is ignored while in reset.
- Latency: 1 cycle. A word accepted at edge n appears on lane_data/valid_out after edge n.
- Accept (valid_in=1, flush=0): lane[ptr]<=data_input; valid_out<=onehot(ptr); other lanes hold data with valid 0. If ptr==cfg_active: ptr<=0 and stripe_done<=1. Otherwise ptr<=ptr+1 and stripe_done<=0.
- Idle (valid_in=0, flush=0): valid_out=0, stripe_done=0, lane_data holds, ptr holds.
- Reconfiguration: lane_cfg is sampled into cfg_active only at a stripe boundary:
  - ptr==0 and no accept this cycle, or
  - the cycle in which ptr wraps to 0, or
  - any flush cycle.
  Changes to lane_cfg mid-stripe take no effect until the next boundary. The wrap comparison always uses the old cfg_active.
- Flush with ptr!=0: partial_cnt<=partial_cnt+1, saturating at 255. Flush with ptr==0 does not count.
- Flush with valid_in=0: ptr<=0, valid_out=0, stripe_done=0.
- Flush with valid_in=1 (same cycle): the old stripe is aborted first, then the word is written to lane 0 and ptr<=1. If the new cfg_active==0, ptr<=0 and stripe_done=1 instead.
- cfg_active==0 (single lane): every accepted word goes to lane 0 with stripe_done=1.
- Lanes above cfg_active are never written and keep their last data.
- Reset mid-stripe: discards the partial stripe without incrementing partial_cnt.
- State: ptr (PTR_W), cfg_active, partial_cnt, lane registers. No other FSM state.

Test Plan:
1. reset=0 for 2 cycles, then reset=1 with lane_cfg=3. Feed valid words AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD -> valid_out 0001, 0010, 0100, 1000 on successive cycles; lanes 0..3 hold those words; stripe_done=1 only with 1000.
2. lane_cfg=1; feed 11111111, 22222222, 33333333 -> lanes 0/1/0 get the words in order; stripe_done after the 2nd word; lanes 2..3 unchanged.
3. With lane_cfg=3, accept 2 words, switch lane_cfg=1, accept 2 more -> all 4 lanes written (cfg_active stays 3 until wrap); next word goes to lane 0 with cfg_active=1.
4. Accept 2 words, then assert flush with valid_in=1 and data 55555555 -> partial_cnt=1; lane 0=55555555; valid_out=0001; ptr=1.
5. Gap test: valid_in toggles 1,0,1 -> valid_out=0 during the gap; the second word lands in lane 1.
6. Issue 300 flushes each with ptr!=0 -> partial_cnt saturates at 255. Drive reset=0 mid-stripe -> all outputs 0 on the next cycle.
